// File: rtl/spi_reg_bridge_pkg.sv
// Shared types and constants for the SPI-to-register-bus bridge.
// Imported by the bridge top and anything else decoding its command byte.
package spi_reg_bridge_pkg;

    localparam int unsigned DEF_ADDR_W = 7;
    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned CMD_RD_BIT = 7;

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StWrData,
        StRdFetch,
        StRdWait,
        StRdShift
    } state_e;

endpackage

// File: rtl/spi_reg_bridge_evt.sv
// Wrapper-free file kept empty of logic would be pointless; see spi_evt_sync below.
// Two-FF chip-select synchroniser plus rx/tx flag rising-edge and cs falling-edge detectors.
module spi_evt_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic cs,
    input  logic rx_flag,
    input  logic tx_end_flag,
    output logic cs_sync,
    output logic cs_fall,
    output logic rx_evt,
    output logic tx_evt
);

    // [1:0] synchroniser stages, [2] previous synchronised value for edge detection
    logic [2:0] cs_q;
    logic       rx_q;
    logic       tx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_q <= 3'b111;
            rx_q <= 1'b0;
            tx_q <= 1'b0;
        end else begin
            cs_q <= {cs_q[1:0], cs};
            rx_q <= rx_flag;
            tx_q <= tx_end_flag;
        end
    end

    assign cs_sync = cs_q[1];
    assign cs_fall = cs_q[2] & ~cs_q[1];
    assign rx_evt  = rx_flag & ~rx_q;
    assign tx_evt  = tx_end_flag & ~tx_q;

endmodule

// File: rtl/spi_reg_bridge.sv
// Parses a command/address byte from the SPI shifter and runs burst register
// writes or reads on the internal register bus, feeding read data back for transmit.
module spi_reg_bridge
    import spi_reg_bridge_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cs,
    input  logic [7:0]        rx_data,
    input  logic              rx_flag,
    input  logic              tx_end_flag,
    output logic [7:0]        tx_data,
    output logic              trans_flag,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_wdata,
    output logic              reg_wr,
    output logic              reg_rd,
    input  logic [DATA_W-1:0] reg_rdata,
    output logic              busy,
    output logic              frame_err
);

    logic cs_sync, cs_fall, rx_evt, tx_evt;

    spi_evt_sync u_evt_sync (
        .clk         (clk),
        .rst_n       (rst_n),
        .cs          (cs),
        .rx_flag     (rx_flag),
        .tx_end_flag (tx_end_flag),
        .cs_sync     (cs_sync),
        .cs_fall     (cs_fall),
        .rx_evt      (rx_evt),
        .tx_evt      (tx_evt)
    );

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [7:0]        tx_q, tx_d;
    logic              wr_q, wr_d;
    logic              trans_q, trans_d;
    logic              err_q, err_d;
    logic              tx_seen_q, tx_seen_d;
    logic [1:0]        cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            wdata_q   <= '0;
            tx_q      <= '0;
            wr_q      <= 1'b0;
            trans_q   <= 1'b0;
            err_q     <= 1'b0;
            tx_seen_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            tx_q      <= tx_d;
            wr_q      <= wr_d;
            trans_q   <= trans_d;
            err_q     <= err_d;
            tx_seen_q <= tx_seen_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        tx_d      = tx_q;
        wr_d      = 1'b0;
        trans_d   = trans_q;
        err_d     = err_q;
        tx_seen_d = tx_seen_q;
        cnt_d     = cnt_q;

        // Post-increment once the write strobe has been presented at the old address
        if (wr_q) begin
            addr_d = addr_q + ADDR_W'(1);
        end

        if (state_q != StIdle && cs_sync) begin
            // cs release beats any same-cycle byte; a clocked-but-unfinished command byte is an error
            state_d = StIdle;
            trans_d = 1'b0;
            tx_d    = '0;
            if (state_q == StCmd && (tx_seen_q || tx_evt)) begin
                err_d = 1'b1;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cs_fall) begin
                        state_d   = StCmd;
                        err_d     = 1'b0;
                        trans_d   = 1'b0;
                        tx_seen_d = 1'b0;
                    end
                end
                StCmd: begin
                    if (tx_evt) begin
                        tx_seen_d = 1'b1;
                    end
                    if (rx_evt) begin
                        addr_d  = rx_data[ADDR_W-1:0];
                        state_d = rx_data[CMD_RD_BIT] ? StRdFetch : StWrData;
                    end
                end
                StWrData: begin
                    if (rx_evt) begin
                        wdata_d = DATA_W'(rx_data);
                        wr_d    = 1'b1;
                    end
                end
                StRdFetch: begin
                    state_d = StRdWait;
                    cnt_d   = '0;
                    if (rx_evt) begin
                        err_d = 1'b1;
                    end
                end
                StRdWait: begin
                    if (rx_evt) begin
                        err_d = 1'b1;
                    end
                    if (cnt_q == 2'(RD_LAT - 1)) begin
                        tx_d    = 8'(reg_rdata);
                        trans_d = 1'b1;
                        state_d = StRdShift;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
                StRdShift: begin
                    if (tx_evt) begin
                        addr_d  = addr_q + ADDR_W'(1);
                        state_d = StRdFetch;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Read strobe is the single-cycle fetch state itself, saving a cycle of read latency
    assign reg_rd     = (state_q == StRdFetch);
    assign reg_wr     = wr_q;
    assign reg_addr   = addr_q;
    assign reg_wdata  = wdata_q;
    assign tx_data    = tx_q;
    assign trans_flag = trans_q;
    assign frame_err  = err_q;
    assign busy       = (state_q != StIdle) && !cs_sync;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Scoreboard bench for spi_reg_bridge: expected register-bus strobes are queued as
// stimulus is driven and compared against strobes observed on the bus.
module tb_spi_reg_bridge;

    localparam int unsigned ADDR_W = 7;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned RD_LAT = 1;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cs = 1'b1;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_flag = 1'b0;
    logic              tx_end_flag = 1'b0;
    logic [7:0]        tx_data;
    logic              trans_flag;
    logic [ADDR_W-1:0] reg_addr;
    logic [DATA_W-1:0] reg_wdata;
    logic              reg_wr;
    logic              reg_rd;
    logic [DATA_W-1:0] reg_rdata;
    logic              busy;
    logic              frame_err;

    int vectors = 0;
    int miscompares = 0;

    // Entries carry a leading valid bit so a missing observation can never equal an expectation
    logic [15:0] wr_exp[$];
    logic [15:0] wr_obs[$];
    logic [7:0]  rd_exp[$];
    logic [7:0]  rd_obs[$];

    spi_reg_bridge #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cs          (cs),
        .rx_data     (rx_data),
        .rx_flag     (rx_flag),
        .tx_end_flag (tx_end_flag),
        .tx_data     (tx_data),
        .trans_flag  (trans_flag),
        .reg_addr    (reg_addr),
        .reg_wdata   (reg_wdata),
        .reg_wr      (reg_wr),
        .reg_rd      (reg_rd),
        .reg_rdata   (reg_rdata),
        .busy        (busy),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    // Register file model: data = addr ^ 0x55, one cycle after the read strobe
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) reg_rdata <= '0;
        else if (reg_rd) reg_rdata <= {1'b0, reg_addr} ^ 8'h55;
    end

    task automatic tick();
        @(negedge clk);
        if (reg_wr) wr_obs.push_back({1'b1, reg_addr, reg_wdata});
        if (reg_rd) rd_obs.push_back({1'b1, reg_addr});
    endtask

    task automatic wait_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic cs_low();
        cs = 1'b0;
        wait_n(4);
    endtask

    task automatic cs_high();
        cs = 1'b1;
        wait_n(5);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_flag = 1'b0;
        wait_n(6);
        rx_data = b;
        rx_flag = 1'b1;
        wait_n(3);
    endtask

    task automatic test_reset();
        wait_n(2);
        vectors++;
        if ({tx_data, trans_flag, reg_addr, reg_wdata} !== '0) begin
            miscompares++;
            $display("FAIL reset_data: tx=%h trans=%b addr=%h wdata=%h, want all 0",
                     tx_data, trans_flag, reg_addr, reg_wdata);
        end
        vectors++;
        if ({reg_wr, reg_rd, busy, frame_err} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_ctrl: wr/rd/busy/err=%b, want 0000",
                     {reg_wr, reg_rd, busy, frame_err});
        end
        rst_n = 1'b1;
        wait_n(3);
    endtask

    task automatic test_write_burst();
        wr_obs.delete();
        rd_obs.delete();
        wr_exp.push_back({1'b1, 7'h05, 8'hA1});
        wr_exp.push_back({1'b1, 7'h06, 8'hB2});
        cs_low();
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL wr_busy_start: busy=%b want 1", busy);
        end
        send_byte(8'h05);
        send_byte(8'hA1);
        send_byte(8'hB2);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL wr_busy_mid: busy=%b want 1", busy);
        end
        cs_high();
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL wr_busy_end: busy=%b want 0", busy);
        end
        vectors++;
        if (wr_obs.size() != wr_exp.size() || rd_obs.size() != 0) begin
            miscompares++;
            $display("FAIL wr_count: writes=%0d reads=%0d want %0d/0",
                     wr_obs.size(), rd_obs.size(), wr_exp.size());
        end
        while (wr_exp.size() != 0) begin
            logic [15:0] e, g;
            e = wr_exp.pop_front();
            g = (wr_obs.size() != 0) ? wr_obs.pop_front() : 16'h0000;
            vectors++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL wr_burst: got addr=%h data=%h want addr=%h data=%h",
                         g[14:8], g[7:0], e[14:8], e[7:0]);
            end
        end
    endtask

    task automatic test_read_burst();
        logic ok;
        wr_obs.delete();
        rd_obs.delete();
        rd_exp.push_back({1'b1, 7'h10});
        rd_exp.push_back({1'b1, 7'h11});
        cs_low();
        rx_flag = 1'b0;
        wait_n(4);
        rx_data = 8'h90;
        rx_flag = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (tx_data === 8'h45 && trans_flag === 1'b1) ok = 1'b1;
        end
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL rd_first_lat: tx=%h trans=%b want 45/1 within 3 cycles",
                     tx_data, trans_flag);
        end
        tx_end_flag = 1'b0;
        wait_n(5);
        vectors++;
        if (tx_data !== 8'h45 || trans_flag !== 1'b1) begin
            miscompares++;
            $display("FAIL rd_hold: tx=%h trans=%b want 45/1", tx_data, trans_flag);
        end
        tx_end_flag = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (tx_data === 8'h44) ok = 1'b1;
        end
        vectors++;
        if (!ok || trans_flag !== 1'b1) begin
            miscompares++;
            $display("FAIL rd_second: tx=%h trans=%b want 44/1", tx_data, trans_flag);
        end
        wait_n(3);
        vectors++;
        if (frame_err !== 1'b0) begin
            miscompares++;
            $display("FAIL rd_no_err: frame_err=%b want 0", frame_err);
        end
        cs_high();
        vectors++;
        if (tx_data !== 8'h00 || trans_flag !== 1'b0) begin
            miscompares++;
            $display("FAIL rd_cs_release: tx=%h trans=%b want 00/0", tx_data, trans_flag);
        end
        vectors++;
        if (rd_obs.size() != rd_exp.size() || wr_obs.size() != 0) begin
            miscompares++;
            $display("FAIL rd_count: reads=%0d writes=%0d want %0d/0",
                     rd_obs.size(), wr_obs.size(), rd_exp.size());
        end
        while (rd_exp.size() != 0) begin
            logic [7:0] e, g;
            e = rd_exp.pop_front();
            g = (rd_obs.size() != 0) ? rd_obs.pop_front() : 8'h00;
            vectors++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL rd_addr: got %h want %h", g[6:0], e[6:0]);
            end
        end
    endtask

    task automatic test_addr_wrap();
        wr_obs.delete();
        wr_exp.push_back({1'b1, 7'h7F, 8'h11});
        wr_exp.push_back({1'b1, 7'h00, 8'h22});
        cs_low();
        send_byte(8'h7F);
        send_byte(8'h11);
        send_byte(8'h22);
        cs_high();
        vectors++;
        if (wr_obs.size() != wr_exp.size()) begin
            miscompares++;
            $display("FAIL wrap_count: writes=%0d want %0d", wr_obs.size(), wr_exp.size());
        end
        while (wr_exp.size() != 0) begin
            logic [15:0] e, g;
            e = wr_exp.pop_front();
            g = (wr_obs.size() != 0) ? wr_obs.pop_front() : 16'h0000;
            vectors++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL wrap: got addr=%h data=%h want addr=%h data=%h",
                         g[14:8], g[7:0], e[14:8], e[7:0]);
            end
        end
    endtask

    task automatic test_early_cs();
        rd_obs.delete();
        cs_low();
        send_byte(8'h83);
        wait_n(2);
        vectors++;
        if (tx_data !== 8'h56 || trans_flag !== 1'b1) begin
            miscompares++;
            $display("FAIL early_loaded: tx=%h trans=%b want 56/1", tx_data, trans_flag);
        end
        cs_high();
        wait_n(5);
        vectors++;
        if (tx_data !== 8'h00 || trans_flag !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL early_idle: tx=%h trans=%b busy=%b want 00/0/0",
                     tx_data, trans_flag, busy);
        end
        vectors++;
        if (rd_obs.size() != 1 || (rd_obs.size() == 1 && rd_obs[0] !== {1'b1, 7'h03})) begin
            miscompares++;
            $display("FAIL early_reads: count=%0d want exactly one read at 03", rd_obs.size());
        end
        vectors++;
        if (frame_err !== 1'b0) begin
            miscompares++;
            $display("FAIL early_err: frame_err=%b want 0", frame_err);
        end
    endtask

    task automatic test_reset_mid_write();
        wr_obs.delete();
        wr_exp.push_back({1'b1, 7'h20, 8'h99});
        wr_exp.push_back({1'b1, 7'h30, 8'h77});
        cs_low();
        send_byte(8'h20);
        rx_flag = 1'b0;
        wait_n(6);
        rx_data = 8'h99;
        rx_flag = 1'b1;
        tick();
        vectors++;
        if (reg_wr !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_pre_strobe: reg_wr=%b want 1", reg_wr);
        end
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({reg_wr, reg_rd, busy, frame_err, trans_flag} !== 5'b0 ||
            {tx_data, reg_addr, reg_wdata} !== '0) begin
            miscompares++;
            $display("FAIL rst_mid: wr=%b rd=%b busy=%b tx=%h addr=%h wdata=%h want all 0",
                     reg_wr, reg_rd, busy, tx_data, reg_addr, reg_wdata);
        end
        tick();
        rx_flag = 1'b0;
        cs = 1'b1;
        wait_n(2);
        rst_n = 1'b1;
        wait_n(4);
        cs_low();
        send_byte(8'h30);
        send_byte(8'h77);
        cs_high();
        vectors++;
        if (wr_obs.size() != wr_exp.size()) begin
            miscompares++;
            $display("FAIL rst_count: writes=%0d want %0d", wr_obs.size(), wr_exp.size());
        end
        while (wr_exp.size() != 0) begin
            logic [15:0] e, g;
            e = wr_exp.pop_front();
            g = (wr_obs.size() != 0) ? wr_obs.pop_front() : 16'h0000;
            vectors++;
            if (g !== e) begin
                miscompares++;
                $display("FAIL rst_write: got addr=%h data=%h want addr=%h data=%h",
                         g[14:8], g[7:0], e[14:8], e[7:0]);
            end
        end
    endtask

    task automatic test_level_hold();
        wr_obs.delete();
        rd_obs.delete();
        cs_low();
        send_byte(8'h40);
        rx_flag = 1'b0;
        wait_n(6);
        rx_data = 8'h5A;
        rx_flag = 1'b1;
        wait_n(40);
        cs_high();
        vectors++;
        if (wr_obs.size() != 1 || (wr_obs.size() == 1 && wr_obs[0] !== {1'b1, 7'h40, 8'h5A})) begin
            miscompares++;
            $display("FAIL hold_single: writes=%0d want exactly one at 40=5A", wr_obs.size());
        end
        // Read command, then a second rx event lands while the fetch is still waiting
        cs_low();
        rx_flag = 1'b0;
        wait_n(4);
        rx_data = 8'h81;
        rx_flag = 1'b1;
        tick();
        rx_flag = 1'b0;
        tick();
        rx_flag = 1'b1;
        wait_n(4);
        vectors++;
        if (frame_err !== 1'b1) begin
            miscompares++;
            $display("FAIL early_clock_err: frame_err=%b want 1", frame_err);
        end
        cs_high();
        vectors++;
        if (frame_err !== 1'b1) begin
            miscompares++;
            $display("FAIL err_sticky: frame_err=%b want 1", frame_err);
        end
        cs_low();
        vectors++;
        if (frame_err !== 1'b0) begin
            miscompares++;
            $display("FAIL err_clear: frame_err=%b want 0", frame_err);
        end
        cs_high();
    endtask

    task automatic test_partial_byte();
        cs_low();
        tx_end_flag = 1'b0;
        tick();
        tx_end_flag = 1'b1;
        wait_n(3);
        cs_high();
        vectors++;
        if (frame_err !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL partial_byte: frame_err=%b busy=%b want 1/0", frame_err, busy);
        end
    endtask

    initial begin
        test_reset();
        test_write_burst();
        test_read_burst();
        test_addr_wrap();
        test_early_cs();
        test_reset_mid_write();
        test_level_hold();
        test_partial_byte();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/spi_reg_bridge.md
Name: spi_reg_bridge

Overview:
- Downstream stage of the byte-level SPI slave shifter.
- Consumes received bytes and their flags, parses a command/address byte, then performs burst register writes or reads on a simple internal register bus.
- In read mode it drives the transmit byte and the transmit-mode select back to the shifter.
- Sits between the SPI slave shifter and the FPGA register file.

Parameters:
ADDR_W, 7, register address width; equals command byte bits [6:0]
DATA_W, 8, register data width; fixed to the SPI byte width
RD_LAT, 1, register-file read latency in clk cycles (1 or 2)

Ports:
clk  input  1  main clock, same as the shifter (>=50 MHz)
rst_n  input  1  asynchronous active-low reset
cs  input  1  SPI chip select, active-low, raw pin; synchronised internally with 2 FFs
rx_data  input  8  received byte from the shifter
rx_flag  input  1  shifter receive flag; level, stays high until the next shift
tx_end_flag  input  1  shifter transmit-done flag; level
tx_data  output  8  byte for the shifter to transmit, MSB first
trans_flag  output  1  1 = shifter in transmit mode
reg_addr  output  ADDR_W  register bus address
reg_wdata  output  DATA_W  register write data
reg_wr  output  1  one-cycle write strobe
reg_rd  output  1  one-cycle read strobe
reg_rdata  input  DATA_W  read data, valid RD_LAT cycles after reg_rd
busy  output  1  high while a frame is active (cs low, state != IDLE)
frame_err  output  1  sticky; cleared at next frame start

Behaviour:
- Reset values: tx_data=0, trans_flag=0, reg_addr=0, reg_wdata=0, reg_wr=0, reg_rd=0, busy=0, frame_err=0. FSM resets to IDLE. cs synchroniser resets to 1.
- rx_flag and tx_end_flag are edge-detected: an event is a 0->1 transition between consecutive clk samples. Levels alone never trigger anything.
- FSM states: IDLE, CMD, WR_DATA, RD_FETCH, RD_WAIT, RD_SHIFT.
- IDLE:
  - On the falling edge of synchronised cs: go to CMD, clear frame_err, trans_flag=0.
- CMD:
  - On an rx event: reg_addr <= rx_data[6:0].
  - rx_data[7]=0 -> WR_DATA.
  - rx_data[7]=1 -> RD_FETCH.
- WR_DATA, on each rx event:
  - reg_wdata <= rx_data; reg_wr=1 on the following cycle for exactly 1 cycle, at the current reg_addr.
  - reg_addr then increments, wrapping 127->0.
- RD_FETCH:
  - Pulse reg_rd for 1 cycle, then go to RD_WAIT.
- RD_WAIT:
  - Wait RD_LAT cycles, then tx_data <= reg_rdata, trans_flag <= 1, go to RD_SHIFT.
  - Total latency from the command rx event to tx_data valid = RD_LAT+2 clk cycles. This must complete before the first sck rising edge of the next byte.
- RD_SHIFT:
  - On a tx_end event: reg_addr increments with wrap, then go to RD_FETCH for the next burst byte.
  - tx_data holds stable for the whole byte; it never changes while the shifter is shifting.
- Burst length is unlimited in both read and write modes.
- cs deassert (synchronised cs=1) in any state:
  - Go to IDLE next cycle; trans_flag=0, tx_data=0.
  - Any pending reg_wr/reg_rd strobe still completes its single cycle; no new strobe is issued.
  - reg_addr holds its value.
- frame_err is set when:
  - an rx event occurs in RD_FETCH or RD_WAIT (host clocked too early); or
  - cs deasserts in CMD after at least one sck edge without a complete byte (rx event absent but tx_end event seen).
- Simultaneous rx event and cs deassert in the same cycle: cs wins and the byte is dropped.
- rx/tx events in IDLE are ignored.
- Asynchronous reset mid-frame: everything returns to reset values immediately; strobes are cut.

Decomposition:
- Shared package: state encoding constants (IDLE..RD_SHIFT), CMD_RD_BIT=7, default ADDR_W/DATA_W.
- One natural sub-module: spi_evt_sync. It provides the 2-FF cs synchroniser plus rising-edge detectors for rx_flag/tx_end_flag and a falling-edge detector for cs. It is reused by other SPI-fed blocks.

Test Plan:
- Write burst: cs low, bytes 0x05,0xA1,0xB2 -> reg_wr pulses at addr 0x05 data 0xA1, then addr 0x06 data 0xB2; no reg_rd; busy=1 until cs high.
- Read burst, RD_LAT=1, rdata model = addr XOR 0x55: byte 0x90 then two transmit bytes -> reg_rd at addr 0x10, tx_data=0x45 within 3 cycles of the rx event; after tx_end, reg_rd at 0x11, tx_data=0x44; trans_flag=1 throughout.
- Address wrap: write command 0x7F with data 0x11,0x22 -> writes at 0x7F then 0x00.
- Early cs deassert: cs high after command byte 0x83 before any transmit byte -> IDLE, trans_flag=0, tx_data=0, no further reg_rd.
- Reset mid-write: assert rst_n=0 one cycle after the rx event of a data byte -> reg_wr=0 immediately; all outputs at reset values; next frame decodes normally.
- Level-hold robustness: rx_flag held high 40 cycles -> exactly one reg_wr; a premature rx event in RD_WAIT sets frame_err=1, which clears at the next cs falling edge.
